// File: rtl/dbg_loader_if.sv
// ----------------------------------------------------------------------------
// dbg_loader_if: byte-stream input and debug-write bus of the program loader.
//
// Signals
//   rx_data    [7:0]        received byte
//   rx_valid                one-cycle strobe, rx_data valid
//   dbg_ack                 memory accepted the current debug write
//   dbg_mem_op              debug write request
//   dbg_wren   [DATA_W/8]   byte enables (all ones during a write)
//   dbg_adr    [ADDR_W]     write address
//   dbg_do     [DATA_W]     write data
//
// Modports
//   master : the loader (consumes rx, drives the debug write port)
//   slave  : the environment (UART RX path and SoC memory)
// ----------------------------------------------------------------------------
interface dbg_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                dbg_ack;
  logic                dbg_mem_op;
  logic [DATA_W/8-1:0] dbg_wren;
  logic [ADDR_W-1:0]   dbg_adr;
  logic [DATA_W-1:0]   dbg_do;

  modport master (
    input  rx_data, rx_valid, dbg_ack,
    output dbg_mem_op, dbg_wren, dbg_adr, dbg_do
  );

  modport slave (
    output rx_data, rx_valid, dbg_ack,
    input  dbg_mem_op, dbg_wren, dbg_adr, dbg_do
  );
endinterface

// File: rtl/dbg_loader.sv
// ----------------------------------------------------------------------------
// dbg_loader: framed program loader for the darkriscv SoC debug write port.
//
// Parses MAGIC | base address | word count N | N words | checksum (all
// little-endian) from a byte stream, writes each word through the debug write
// port and holds the CPU in reset while a frame is being loaded.
//
// Ports
//   CLK, RES      clock, synchronous active-high reset
//   bus           dbg_loader_if.master (rx byte stream + debug write port)
//   cpu_n_reset   CPU reset, low while loading or after an error
//   busy          frame in progress
//   done          one-cycle pulse after a frame with a good checksum
//   err           sticky error (bad checksum, skid overflow, timeout)
//   dbg_state_o   current FSM state, for observation only
//
// Handshakes: rx_valid is a one-cycle strobe with no back-pressure; a byte is
// taken in the cycle rx_valid is high. The debug write is valid/ready style:
// dbg_mem_op is the valid, dbg_ack the ready; address, data and enables stay
// constant from the cycle dbg_mem_op rises until the cycle dbg_ack is seen,
// and the transfer completes in that cycle.
// ----------------------------------------------------------------------------
module dbg_loader #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  MAGIC       = 8'hA5
) (
  input  logic             CLK,
  input  logic             RES,
  dbg_loader_if.master     bus,
  output logic             cpu_n_reset,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       dbg_state_o
);

  localparam int unsigned WB = DATA_W / 8;
  localparam int unsigned AB = ADDR_W / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CNT, S_DATA, S_WRITE, S_CSUM, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [7:0]        bcnt_q, bcnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        skid_q, skid_d;
  logic              skid_vld_q, skid_vld_d;
  logic [31:0]       timer_q, timer_d;
  logic              mem_op_q, mem_op_d;
  logic [WB-1:0]     wren_q, wren_d;
  logic              cpu_n_rst_q, cpu_n_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              consuming;
  logic              in_vld;
  logic [7:0]        in_byte;
  logic [15:0]       cnt_next;
  logic              fail;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    bcnt_d      = bcnt_q;
    csum_d      = csum_q;
    skid_d      = skid_q;
    skid_vld_d  = skid_vld_q;
    timer_d     = timer_q;
    mem_op_d    = mem_op_q;
    wren_d      = wren_q;
    cpu_n_rst_d = cpu_n_rst_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    fail        = 1'b0;
    cnt_next    = {in_byte, cnt_q[15:8]};

    // The skid byte (captured during a stalled write) is older than whatever
    // is on rx_data now, so it is always consumed first.
    consuming = (state_q == S_ADDR) || (state_q == S_CNT) ||
                (state_q == S_DATA) || (state_q == S_CSUM);
    in_vld    = skid_vld_q | bus.rx_valid;
    in_byte   = skid_vld_q ? skid_q : bus.rx_data;

    // Release the CPU the cycle after the done pulse.
    if (done_q) cpu_n_rst_d = 1'b1;

    if (consuming) begin
      if (skid_vld_q) begin
        // Skid byte consumed; a byte arriving now takes its place.
        skid_d     = bus.rx_data;
        skid_vld_d = bus.rx_valid;
      end
      // Idle-cycle counter; held (not cleared) while a write is stalled.
      if (TIMEOUT_CYC != 0) begin
        if (bus.rx_valid)                         timer_d = 32'd0;
        else if (timer_q == TIMEOUT_CYC - 32'd1)  fail    = 1'b1;
        else                                      timer_d = timer_q + 32'd1;
      end
    end

    case (state_q)
      S_IDLE, S_ERR: begin
        if (bus.rx_valid && bus.rx_data == MAGIC) begin
          state_d     = S_ADDR;
          cpu_n_rst_d = 1'b0;
          busy_d      = 1'b1;
          err_d       = 1'b0;
          csum_d      = 8'd0;
          bcnt_d      = 8'd0;
          timer_d     = 32'd0;
          skid_vld_d  = 1'b0;
        end
      end

      // Fields arrive LSB first: shift each byte in at the top.
      S_ADDR: begin
        if (in_vld) begin
          addr_d                 = addr_q >> 8;
          addr_d[ADDR_W-1 -: 8]  = in_byte;
          csum_d                 = csum_q + in_byte;
          if (bcnt_q == 8'(AB - 1)) begin
            bcnt_d  = 8'd0;
            state_d = S_CNT;
          end else begin
            bcnt_d  = bcnt_q + 8'd1;
          end
        end
      end

      S_CNT: begin
        if (in_vld) begin
          cnt_d  = cnt_next;
          csum_d = csum_q + in_byte;
          if (bcnt_q == 8'd1) begin
            bcnt_d  = 8'd0;
            state_d = (cnt_next == 16'd0) ? S_CSUM : S_DATA;
          end else begin
            bcnt_d  = bcnt_q + 8'd1;
          end
        end
      end

      S_DATA: begin
        if (in_vld) begin
          word_d                 = word_q >> 8;
          word_d[DATA_W-1 -: 8]  = in_byte;
          csum_d                 = csum_q + in_byte;
          if (bcnt_q == 8'(WB - 1)) begin
            bcnt_d   = 8'd0;
            state_d  = S_WRITE;
            mem_op_d = 1'b1;
            wren_d   = '1;
          end else begin
            bcnt_d   = bcnt_q + 8'd1;
          end
        end
      end

      S_WRITE: begin
        if (bus.rx_valid) begin
          if (skid_vld_q) begin
            fail = 1'b1;
          end else begin
            skid_d     = bus.rx_data;
            skid_vld_d = 1'b1;
          end
        end
        if (bus.dbg_ack) begin
          mem_op_d = 1'b0;
          wren_d   = '0;
          addr_d   = addr_q + ADDR_W'(WB);
          cnt_d    = cnt_q - 16'd1;
          state_d  = (cnt_q == 16'd1) ? S_CSUM : S_DATA;
        end
      end

      S_CSUM: begin
        if (in_vld) begin
          if (in_byte == csum_q) begin
            state_d    = S_IDLE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            skid_vld_d = 1'b0;
          end else begin
            fail = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Any error: abandon the frame, drop a pending write request, keep the
    // CPU in reset. Words already written stay in memory.
    if (fail) begin
      state_d     = S_ERR;
      err_d       = 1'b1;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      cpu_n_rst_d = 1'b0;
      mem_op_d    = 1'b0;
      wren_d      = '0;
      skid_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      bcnt_q      <= '0;
      csum_q      <= '0;
      skid_q      <= '0;
      skid_vld_q  <= 1'b0;
      timer_q     <= '0;
      mem_op_q    <= 1'b0;
      wren_q      <= '0;
      cpu_n_rst_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      bcnt_q      <= bcnt_d;
      csum_q      <= csum_d;
      skid_q      <= skid_d;
      skid_vld_q  <= skid_vld_d;
      timer_q     <= timer_d;
      mem_op_q    <= mem_op_d;
      wren_q      <= wren_d;
      cpu_n_rst_q <= cpu_n_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.dbg_mem_op = mem_op_q;
  assign bus.dbg_wren   = wren_q;
  assign bus.dbg_adr    = addr_q;
  assign bus.dbg_do     = word_q;
  assign cpu_n_reset    = cpu_n_rst_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_dbg_loader.sv
// ----------------------------------------------------------------------------
// tb_dbg_loader: self-checking bench for dbg_loader (DATA_W=32, ADDR_W=32,
// TIMEOUT_CYC=50). A memory responder acknowledges writes after a
// programmable delay and checks each accepted write against exp_q, which the
// frame builder fills from the frame contents.
// ----------------------------------------------------------------------------
module tb_dbg_loader;

  logic       clk;
  logic       RES;
  logic       cpu_n_reset, busy, done, err;
  logic [2:0] dbg_state;

  dbg_loader_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  dbg_loader #(
    .DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(50), .MAGIC(8'hA5)
  ) dut (
    .CLK(clk), .RES(RES), .bus(bus.master),
    .cpu_n_reset(cpu_n_reset), .busy(busy), .done(done), .err(err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];          // {address, data} of each expected write
  int          ack_delay = 0;
  int          writes_seen = 0;
  logic [31:0] frame_words[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_delay stall cycles, checks the bus is
  // held stable while stalled and compares accepted writes with exp_q.
  initial begin
    int          wait_cnt;
    logic [31:0] hold_adr, hold_do;
    logic [63:0] e;
    bus.dbg_ack = 1'b0;
    wait_cnt    = 0;
    hold_adr    = '0;
    hold_do     = '0;
    forever begin
      @(negedge clk);
      if (!bus.dbg_mem_op) begin
        bus.dbg_ack = 1'b0;
        wait_cnt    = 0;
      end else begin
        if (wait_cnt == 0) begin
          hold_adr = bus.dbg_adr;
          hold_do  = bus.dbg_do;
          check("wr_wren", 64'(bus.dbg_wren), 64'hF);
        end else begin
          check("stall_adr_stable", 64'(bus.dbg_adr), 64'(hold_adr));
          check("stall_do_stable", 64'(bus.dbg_do), 64'(hold_do));
        end
        if (wait_cnt >= ack_delay) begin
          bus.dbg_ack = 1'b1;
          writes_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_write", 64'(bus.dbg_adr), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("wr_adr", 64'(bus.dbg_adr), 64'(e[63:32]));
            check("wr_data", 64'(bus.dbg_do), 64'(e[31:0]));
          end
        end else begin
          bus.dbg_ack = 1'b0;
        end
        wait_cnt++;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; the byte is consumed at the following posedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Reference model: build the frame from its field definitions, queue the
  // expected writes (base + 4*i mod 2^32), send it and check the outcome.
  task automatic run_frame(input logic [31:0] base, input int n, input int delta,
                           input int gap, input int delay,
                           input bit exp_done, input bit exp_err);
    logic [7:0]  bytes[$];
    logic [7:0]  sum;
    logic [15:0] nn;
    logic [31:0] w;
    bit          rst_bad;
    bit          got_done;
    ack_delay   = delay;
    writes_seen = 0;
    nn          = 16'(n);
    bytes       = {};
    for (int i = 0; i < 4; i++) bytes.push_back(base[8*i +: 8]);
    bytes.push_back(nn[7:0]);
    bytes.push_back(nn[15:8]);
    for (int i = 0; i < n; i++) begin
      w = frame_words[i];
      for (int j = 0; j < 4; j++) bytes.push_back(w[8*j +: 8]);
      exp_q.push_back({base + 32'(4 * i), w});
    end
    sum = 8'd0;
    foreach (bytes[k]) sum = sum + bytes[k];
    send_byte(8'hA5, gap);
    rst_bad = (cpu_n_reset !== 1'b0) || (busy !== 1'b1);
    foreach (bytes[k]) begin
      send_byte(bytes[k], gap);
      if (cpu_n_reset !== 1'b0) rst_bad = 1'b1;
    end
    send_byte(sum + 8'(delta), 0);
    check("cpu_rst_low_in_frame", 64'(rst_bad), 64'd0);
    if (n == 0 && exp_done) check("done_latency_n0", 64'(done), 64'd1);
    got_done = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (done) begin
        got_done = 1'b1;
        check("cpu_rst_at_done", 64'(cpu_n_reset), 64'd0);
        @(negedge clk);
        check("cpu_rst_released", 64'(cpu_n_reset), 64'd1);
        check("done_one_cycle", 64'(done), 64'd0);
        break;
      end
      if (err) break;
      @(negedge clk);
    end
    check("done", 64'(got_done), 64'(exp_done));
    check("err", 64'(err), 64'(exp_err));
    check("busy_after", 64'(busy), 64'd0);
    check("writes_count", 64'(writes_seen), 64'(n));
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    if (exp_err) begin
      repeat (3) @(negedge clk);
      check("cpu_rst_held_on_err", 64'(cpu_n_reset), 64'd0);
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [31:0] base;
    int          n;
    int          delta;
    int          gap;
    int          delay;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] plan_words[4];
    plan_words = '{32'h0001_0537, 32'h0005_2023, 32'h0005_2223, 32'h0000_006F};
    vecs[0] = '{32'h0002_0000, 4, 0, 1, 0, 1'b1, 1'b0};  // reference frame
    vecs[1] = '{32'h0002_0000, 4, 1, 1, 0, 1'b0, 1'b1};  // checksum off by one
    vecs[2] = '{32'h0002_0000, 4, 0, 1, 0, 1'b1, 1'b0};  // recovers from err
    vecs[3] = '{32'hFFFF_FFFC, 2, 0, 2, 1, 1'b1, 1'b0};  // address wrap
    vecs[4] = '{32'h0000_1000, 3, 0, 3, 5, 1'b1, 1'b0};  // 5-cycle ack stall
    vecs[5] = '{32'h0000_0040, 0, 0, 1, 0, 1'b1, 1'b0};  // N = 0
    vecs[6] = '{32'h0000_2000, 1, 0, 1, 2, 1'b1, 1'b0};  // skid absorbs a byte

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    RES = 1'b1;
    repeat (3) @(negedge clk);
    RES = 1'b0;

    // Reset values.
    check("rst_mem_op", 64'(bus.dbg_mem_op), 64'd0);
    check("rst_wren", 64'(bus.dbg_wren), 64'd0);
    check("rst_adr", 64'(bus.dbg_adr), 64'd0);
    check("rst_do", 64'(bus.dbg_do), 64'd0);
    check("rst_status", 64'({cpu_n_reset, busy, done, err}), 64'b1000);

    // Non-MAGIC bytes in IDLE are ignored.
    send_byte(8'h12, 0);
    send_byte(8'h34, 1);
    check("idle_ignores", 64'({cpu_n_reset, busy, err}), 64'b100);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 8; k++) frame_words[k] = plan_words[k % 4];
      run_frame(vecs[i].base, vecs[i].n, vecs[i].delta, vecs[i].gap,
                vecs[i].delay, vecs[i].exp_done, vecs[i].exp_err);
    end

    // Overflow: ack stalled 5 cycles, bytes back-to-back; the first byte in
    // the stall fills the skid register, the second one overflows.
    ack_delay = 5;
    begin
      logic [7:0] ov_bytes[13];
      ov_bytes = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h00, 8'h02, 8'h00,
                   8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      foreach (ov_bytes[k]) send_byte(ov_bytes[k], 0);
    end
    check("ovf_err", 64'(err), 64'd1);
    check("ovf_busy", 64'(busy), 64'd0);
    check("ovf_mem_op_dropped", 64'(bus.dbg_mem_op), 64'd0);
    check("ovf_cpu_rst", 64'(cpu_n_reset), 64'd0);
    repeat (3) @(negedge clk);

    // Timeout: stream stops mid-word (N=1, 2 of 4 data bytes sent).
    ack_delay = 0;
    begin
      logic [7:0] to_bytes[9];
      to_bytes = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
      foreach (to_bytes[k]) send_byte(to_bytes[k], 0);
    end
    check("to_cleared_err", 64'(err), 64'd0);
    repeat (49) @(negedge clk);
    check("to_not_yet", 64'({err, busy}), 64'b01);
    @(negedge clk);
    check("to_fired", 64'({err, busy}), 64'b10);

    // Reset during a stalled write.
    ack_delay = 30;
    begin
      logic [7:0] rs_bytes[11];
      bit         seen;
      rs_bytes = '{8'hA5, 8'h00, 8'h50, 8'h00, 8'h00, 8'h02, 8'h00,
                   8'h01, 8'h02, 8'h03, 8'h04};
      foreach (rs_bytes[k]) send_byte(rs_bytes[k], 1);
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
        if (bus.dbg_mem_op) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("res_write_pending", 64'(seen), 64'd1);
    end
    RES = 1'b1;
    @(negedge clk);
    RES = 1'b0;
    check("res_mem_op", 64'(bus.dbg_mem_op), 64'd0);
    check("res_wren", 64'(bus.dbg_wren), 64'd0);
    check("res_adr", 64'(bus.dbg_adr), 64'd0);
    check("res_do", 64'(bus.dbg_do), 64'd0);
    check("res_status", 64'({cpu_n_reset, busy, done, err}), 64'b1000);
    exp_q = {};
    repeat (2) @(negedge clk);

    // Randomized frames against the model.
    for (int r = 0; r < 20; r++) begin
      int n, gap, delay, delta;
      logic [31:0] base;
      n     = $urandom_range(0, 4);
      gap   = $urandom_range(1, 3);
      delay = $urandom_range(0, 2 * gap);
      delta = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0;
      base  = $urandom;
      for (int k = 0; k < 8; k++) frame_words[k] = $urandom;
      run_frame(base, n, delta, gap, delay, delta == 0, delta != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
